// File: rtl/spart_pkg.sv
// Shared constants for the SPART processor-side bus: register addresses,
// baud divisor table (16x oversample at 50 MHz) and the driver FSM state type.
package spart_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned DIV_W  = 16;
   localparam int unsigned ADDR_W = 2;

   localparam logic [ADDR_W-1:0] ADDR_DATA   = 2'b00;
   localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'b01;
   localparam logic [ADDR_W-1:0] ADDR_DIV_LO = 2'b10;
   localparam logic [ADDR_W-1:0] ADDR_DIV_HI = 2'b11;

   // Index 0 is the rightmost entry: 4800, 9600, 19200, 38400 baud.
   localparam logic [3:0][DIV_W-1:0] DIV_TABLE = {16'h0051, 16'h00A2, 16'h0145, 16'h028B};

   typedef enum logic [2:0] {
      CFG_LO = 3'd0,
      CFG_HI = 3'd1,
      POLL   = 3'd2,
      RD_RX  = 3'd3,
      WR_TX  = 3'd4
   } drv_state_t;

   function automatic logic [DIV_W-1:0] div_lookup(input logic [1:0] sel);
      return DIV_TABLE[sel];
   endfunction

endpackage

// File: rtl/spart_driver_echo_buf.sv
// Echo buffer between SPART receive and transmit. SPART_DRIVER_ECHO_FIFO_EN
// selects a 4-entry circular FIFO; otherwise a single holding register.
module echo_buf
   import spart_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] din_i,
   output logic [DATA_W-1:0] dout_c_o,
   output logic              full_c_o,
   output logic              empty_c_o
);

`ifdef SPART_DRIVER_ECHO_FIFO_EN
   localparam int unsigned DEPTH = 4;
   localparam int unsigned PTR_W = 2;
   localparam int unsigned CNT_W = 3;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              do_push, do_pop;

   assign full_c_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_c_o = (cnt_q == '0);
   assign do_push   = push_i && !full_c_o;
   assign do_pop    = pop_i && !empty_c_o;
   assign dout_c_o  = mem_q[rd_ptr_q];

   // Pointers wrap 3->0 naturally through their 2-bit width.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
         cnt_d    = cnt_q + CNT_W'(1);
      end else if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         cnt_d    = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end
`else
   logic [DATA_W-1:0] data_q, data_d;
   logic              vld_q, vld_d;

   assign full_c_o  = vld_q;
   assign empty_c_o = !vld_q;
   assign dout_c_o  = data_q;

   always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      if (push_i && !vld_q) begin
         data_d = din_i;
         vld_d  = 1'b1;
      end else if (pop_i && vld_q) begin
         vld_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         vld_q  <= vld_d;
      end
   end
`endif

endmodule

// File: rtl/spart_driver.sv
// SPART bus initiator: programs the baud divisor from switches, then polls
// status and echoes received bytes. Echo depth set by SPART_DRIVER_ECHO_FIFO_EN.
module spart_driver
   import spart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        br_cfg,
   output logic              iocs,
   output logic              iorw,
   output logic [ADDR_W-1:0] ioaddr,
   inout  wire  [DATA_W-1:0] databus
);

   // Divisor table is fixed for the nominal clock; other clocks need a new table.
   if (CLK_HZ != 32'd50_000_000) begin : g_nonnominal_clk
   end

   drv_state_t        state_q, state_d;
   logic              act_q, act_d;
   logic [1:0]        sync1_q, sync2_q;
   logic [1:0]        prog_q, prog_d;
   logic              tbr_q, tbr_d;
   logic              rda_q, rda_d;
   logic              iocs_q, iocs_d;
   logic              iorw_q, iorw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DIV_W-1:0]  div_sel;

   logic              buf_push, buf_pop, buf_full, buf_empty;
   logic [DATA_W-1:0] buf_dout;

   // Synchronizer keeps sampling through reset so the first CFG write sees the switches.
   always_ff @(posedge clk) begin
      sync1_q <= br_cfg;
      sync2_q <= sync1_q;
   end

   assign div_sel  = div_lookup(sync2_q);
   assign buf_push = act_q && (state_q == RD_RX);
   assign buf_pop  = act_q && (state_q == WR_TX);

   echo_buf u_echo_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (buf_push),
      .pop_i     (buf_pop),
      .din_i     (databus),
      .dout_c_o  (buf_dout),
      .full_c_o  (buf_full),
      .empty_c_o (buf_empty)
   );

   // State and registered bus outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CFG_LO;
         act_q   <= 1'b0;
         prog_q  <= 2'b00;
         tbr_q   <= 1'b0;
         rda_q   <= 1'b0;
         iocs_q  <= 1'b0;
         iorw_q  <= 1'b1;
         addr_q  <= ADDR_DATA;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         act_q   <= act_d;
         prog_q  <= prog_d;
         tbr_q   <= tbr_d;
         rda_q   <= rda_d;
         iocs_q  <= iocs_d;
         iorw_q  <= iorw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // act_q low means the reset-state access has not been issued yet.
   always_comb begin
      state_d = state_q;
      act_d   = 1'b1;
      prog_d  = prog_q;
      tbr_d   = tbr_q;
      rda_d   = rda_q;
      if (act_q) begin
         case (state_q)
            CFG_LO: state_d = CFG_HI;
            CFG_HI: begin
               state_d = POLL;
               prog_d  = sync2_q;
            end
            POLL: begin
               tbr_d = databus[1];
               rda_d = databus[0];
               if (sync2_q != prog_q)          state_d = CFG_LO;
               else if (rda_d && !buf_full)    state_d = RD_RX;
               else if (tbr_d && !buf_empty)   state_d = WR_TX;
               else                            state_d = POLL;
            end
            RD_RX:   state_d = POLL;
            WR_TX:   state_d = POLL;
            default: state_d = CFG_LO;
         endcase
      end
   end

   // Bus access for the cycle the FSM is entering.
   always_comb begin
      iocs_d  = 1'b1;
      iorw_d  = 1'b1;
      addr_d  = ADDR_STATUS;
      wdata_d = wdata_q;
      case (state_d)
         CFG_LO: begin
            iorw_d  = 1'b0;
            addr_d  = ADDR_DIV_LO;
            wdata_d = div_sel[7:0];
         end
         CFG_HI: begin
            iorw_d  = 1'b0;
            addr_d  = ADDR_DIV_HI;
            wdata_d = div_sel[15:8];
         end
         RD_RX: addr_d = ADDR_DATA;
         WR_TX: begin
            iorw_d  = 1'b0;
            addr_d  = ADDR_DATA;
            wdata_d = buf_dout;
         end
         default: addr_d = ADDR_STATUS;
      endcase
   end

   assign iocs    = iocs_q;
   assign iorw    = iorw_q;
   assign ioaddr  = addr_q;
   assign databus = (iocs_q && !iorw_q) ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_spart_driver.sv
// Scoreboard bench for spart_driver: stimulus queues expected bus accesses,
// the monitor pops and compares each access and checks bus ownership.
module tb_spart_driver;

`ifdef SPART_DRIVER_ECHO_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   typedef struct {
      logic       rw;
      logic [1:0] addr;
      logic [7:0] data;
   } acc_t;

   logic       clk;
   logic       rst_n;
   logic [1:0] br_cfg;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   wire  [7:0] databus;

   logic [7:0] stat;
   logic [7:0] rxb;
   logic       done;
   acc_t       exp_q[$];
   acc_t       e_acc;
   int         n_cmp;
   int         n_err;
   int         acc_idx;

   spart_driver #(.CLK_HZ(50_000_000)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .br_cfg  (br_cfg),
      .iocs    (iocs),
      .iorw    (iorw),
      .ioaddr  (ioaddr),
      .databus (databus)
   );

   // SPART-side responder; drives 00 whenever the driver must be off the bus,
   // so any stray drive from the driver corrupts the observed value.
   assign databus = (iocs && iorw)  ? ((ioaddr == 2'b01) ? stat : rxb) :
                    (iocs && !iorw) ? 8'hzz : 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic rw, input logic [1:0] a, input logic [7:0] d,
                       input logic [7:0] st, input logic [7:0] rx);
      acc_t t;
      stat = st;
      rxb  = rx;
      t.rw = rw; t.addr = a; t.data = d;
      exp_q.push_back(t);
      @(negedge clk);
   endtask

   task automatic poll(input logic [7:0] st);
      step(1'b1, 2'b01, 8'h00, st, 8'h00);
   endtask

   task automatic rdrx(input logic [7:0] rx);
      step(1'b1, 2'b00, 8'h00, 8'h00, rx);
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      step(1'b0, a, d, 8'h00, 8'h00);
   endtask

   // Stimulus
   initial begin
      done   = 1'b0;
      br_cfg = 2'b01;
      stat   = 8'h00;
      rxb    = 8'h00;
      rst_n  = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // reset config at 9600 baud
      wr(2'b10, 8'h45);
      wr(2'b11, 8'h01);
      poll(8'h00);
      poll(8'h00);

      // single echo
      poll(8'h03);
      rdrx(8'hA5);
      poll(8'h02);
      wr(2'b00, 8'hA5);
      poll(8'h00);

      // blocked tx
      poll(8'h01);
      rdrx(8'h3C);
      repeat (20) poll(8'h00);
      poll(8'h02);
      wr(2'b00, 8'h3C);
      poll(8'h00);

      // buffer full, then drain in order
      for (int i = 0; i < DEPTH; i++) begin
         poll(8'h01);
         rdrx(8'(8'h10 + i));
      end
      repeat (4) poll(8'h01);
      for (int i = 0; i < DEPTH; i++) begin
         poll(8'h02);
         wr(2'b00, 8'(8'h10 + i));
      end
      poll(8'h02);
      poll(8'h00);

      // baud change during WR_TX; byte received meanwhile survives reprogram
      poll(8'h01);
      rdrx(8'h5A);
      poll(8'h02);
      br_cfg = 2'b11;
      wr(2'b00, 8'h5A);
      poll(8'h01);
      rdrx(8'h77);
      poll(8'h00);
      wr(2'b10, 8'h51);
      wr(2'b11, 8'h00);
      poll(8'h02);
      wr(2'b00, 8'h77);
      poll(8'h00);

      // reset in the middle of a WR_TX access
      poll(8'h01);
      rdrx(8'hC3);
      poll(8'h02);
      begin
         acc_t t;
         t.rw = 1'b0; t.addr = 2'b00; t.data = 8'hC3;
         stat = 8'h00;
         exp_q.push_back(t);
         #2 rst_n = 1'b0;
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      wr(2'b10, 8'h51);
      wr(2'b11, 8'h00);
      poll(8'h02);
      poll(8'h02);
      poll(8'h00);
      done = 1'b1;
   end

   // Monitor / scoreboard
   initial begin
      n_cmp   = 0;
      n_err   = 0;
      acc_idx = 0;
   end

   always @(negedge clk) begin
      #1;
      if (done) begin
         n_cmp++;
         if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected: %0d accesses never seen, want 0", exp_q.size());
         end
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
         $finish;
      end else begin
         if (iocs) begin
            acc_idx++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL access_%0d: got rw=%0b addr=%0d data=%02h, want no access",
                        acc_idx, iorw, ioaddr, databus);
            end else begin
               e_acc = exp_q.pop_front();
               if (iorw !== e_acc.rw || ioaddr !== e_acc.addr ||
                   (!e_acc.rw && databus !== e_acc.data)) begin
                  n_err++;
                  $display("FAIL access_%0d: got rw=%0b addr=%0d data=%02h, want rw=%0b addr=%0d data=%02h",
                           acc_idx, iorw, ioaddr, databus, e_acc.rw, e_acc.addr, e_acc.data);
               end
            end
            if (iorw) begin
               n_cmp++;
               if (databus !== ((ioaddr == 2'b01) ? stat : rxb)) begin
                  n_err++;
                  $display("FAIL read_contention_%0d: got databus=%02h, want %02h",
                           acc_idx, databus, (ioaddr == 2'b01) ? stat : rxb);
               end
            end
         end
         if (iorw && !iocs) begin
            n_cmp++;
            if (databus !== 8'h00) begin
               n_err++;
               $display("FAIL idle_bus_owned: got databus=%02h, want 00 (driver released)", databus);
            end
         end
         // Reset values must hold without waiting for a clock edge.
         #3;
         if (!rst_n) begin
            n_cmp++;
            if (iocs !== 1'b0 || iorw !== 1'b1 || ioaddr !== 2'b00 || databus !== 8'h00) begin
               n_err++;
               $display("FAIL reset_idle: got iocs=%0b iorw=%0b ioaddr=%0d databus=%02h, want 0 1 0 00",
                        iocs, iorw, ioaddr, databus);
            end
         end
      end
   end

endmodule
